// File: rtl/game_flow_controller_pkg.sv
// Shared definitions for the frog-game flow controller: FSM states,
// object slot indices and the default collision masks / sound codes.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_WIN,
        ST_LOSE,
        ST_BUZ,
        ST_GAMEOVER
    } state_t;

    // draw_req slot of each object; lower index wins the pixel
    localparam int BACKGROUND = 0;
    localparam int WATERFALL  = 1;
    localparam int LOG        = 2;
    localparam int FROG       = 3;
    localparam int ENDBANK    = 4;
    localparam int FRENCH     = 5;

    localparam logic [5:0] DEFAULT_HAZARD_MASK = 6'b100101;
    localparam logic [5:0] DEFAULT_GOAL_MASK   = 6'b010000;

    localparam int WIN_FREQ_CODE  = 1;
    localparam int LOSE_FREQ_CODE = 0;

endpackage

// File: rtl/game_flow_controller_if.sv
// Bundle between the draw units / VGA mux / sound path and the flow controller.
interface game_flow_controller_if #(
    parameter int NUM_OBJ   = 6,
    parameter int MAX_LEVEL = 8,
    parameter int LIVES     = 3,
    parameter int NUM_LOGS  = 4,
    parameter int FREQ_W    = 10
);
    logic [NUM_OBJ-1:0]               draw_req;
    logic                             start;
    logic [$clog2(NUM_OBJ+1)-1:0]     select_mux;
    logic                             win;
    logic                             lose;
    logic                             game_over;
    logic [$clog2(MAX_LEVEL+1)-1:0]   level;
    logic [$clog2(LIVES+1)-1:0]       lives;
    logic [NUM_LOGS-1:0]              log_enable;
    logic [FREQ_W-1:0]                sound_freq;
    logic                             enable_sound;

    modport master (
        output draw_req, start,
        input  select_mux, win, lose, game_over, level, lives,
               log_enable, sound_freq, enable_sound
    );

    modport slave (
        input  draw_req, start,
        output select_mux, win, lose, game_over, level, lives,
               log_enable, sound_freq, enable_sound
    );
endinterface

// File: rtl/game_flow_controller_prio_select.sv
// Fixed-priority pixel selector: lowest set request wins, 0 means background.
module prio_select #(
    parameter int NUM_OBJ = 6,
    parameter int SEL_W   = $clog2(NUM_OBJ + 1)
) (
    input  logic [NUM_OBJ-1:0] req,
    output logic [SEL_W-1:0]   select_mux
);

    // Scan from the top so the lowest index is the last (winning) assignment
    always_comb begin
        select_mux = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (req[i]) select_mux = SEL_W'(i + 1);
        end
    end

endmodule

// File: rtl/game_flow_controller.sv
// Frog-game flow controller: pixel priority, collision win/lose FSM,
// level/lives bookkeeping and timed sound burst.
module game_flow_controller
    import game_pkg::*;
#(
    parameter int               NUM_OBJ     = 6,
    parameter int               FROG_IDX    = FROG,
    parameter logic [NUM_OBJ-1:0] HAZARD_MASK = NUM_OBJ'(DEFAULT_HAZARD_MASK),
    parameter logic [NUM_OBJ-1:0] GOAL_MASK   = NUM_OBJ'(DEFAULT_GOAL_MASK),
    parameter int               NUM_LOGS    = 4,
    parameter int               MAX_LEVEL   = 8,
    parameter int               LIVES       = 3,
    parameter int               BUZ_CYCLES  = 50000000,
    parameter int               FREQ_W      = 10,
    parameter int               WIN_FREQ    = WIN_FREQ_CODE,
    parameter int               LOSE_FREQ   = LOSE_FREQ_CODE
) (
    input logic clk,
    input logic reset,
    game_flow_controller_if.slave bus
);

    localparam int LVL_W = $clog2(MAX_LEVEL + 1);
    localparam int LIV_W = $clog2(LIVES + 1);
    localparam int CNT_W = $clog2(BUZ_CYCLES + 1);

    // The frog never collides with itself
    localparam logic [NUM_OBJ-1:0] FROG_BIT   = NUM_OBJ'(1) << FROG_IDX;
    localparam logic [NUM_OBJ-1:0] HAZARD_EFF = HAZARD_MASK & ~FROG_BIT;
    localparam logic [NUM_OBJ-1:0] GOAL_EFF   = GOAL_MASK & ~FROG_BIT;

    state_t             state_reg, state_next;
    logic [LVL_W-1:0]   level_reg, level_next;
    logic [LIV_W-1:0]   lives_reg, lives_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [FREQ_W-1:0]  freq_reg, freq_next;

    logic frog_hit, hazard_hit, goal_hit;

    prio_select #(.NUM_OBJ(NUM_OBJ)) u_prio (
        .req        (bus.draw_req),
        .select_mux (bus.select_mux)
    );

    assign frog_hit   = bus.draw_req[FROG_IDX];
    assign hazard_hit = frog_hit && (|(bus.draw_req & HAZARD_EFF));
    assign goal_hit   = frog_hit && (|(bus.draw_req & GOAL_EFF));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            level_reg <= LVL_W'(1);
            lives_reg <= LIV_W'(LIVES);
            cnt_reg   <= '0;
            freq_reg  <= FREQ_W'(LOSE_FREQ);
        end else begin
            state_reg <= state_next;
            level_reg <= level_next;
            lives_reg <= lives_next;
            cnt_reg   <= cnt_next;
            freq_reg  <= freq_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        lives_next = lives_reg;
        cnt_next   = cnt_reg;
        freq_next  = freq_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) state_next = ST_PLAY;
            end
            ST_PLAY: begin
                // Hazard beats goal when both overlap the frog
                if (hazard_hit)    state_next = ST_LOSE;
                else if (goal_hit) state_next = ST_WIN;
            end
            ST_WIN: begin
                if (level_reg < LVL_W'(MAX_LEVEL)) level_next = level_reg + LVL_W'(1);
                freq_next  = FREQ_W'(WIN_FREQ);
                cnt_next   = CNT_W'(BUZ_CYCLES - 1);
                state_next = ST_BUZ;
            end
            ST_LOSE: begin
                lives_next = lives_reg - LIV_W'(1);
                if (level_reg > LVL_W'(1)) level_next = level_reg - LVL_W'(1);
                freq_next  = FREQ_W'(LOSE_FREQ);
                cnt_next   = CNT_W'(BUZ_CYCLES - 1);
                state_next = ST_BUZ;
            end
            ST_BUZ: begin
                if (cnt_reg != '0)        cnt_next   = cnt_reg - CNT_W'(1);
                else if (lives_reg == '0) state_next = ST_GAMEOVER;
                else                      state_next = ST_PLAY;
            end
            ST_GAMEOVER: begin
                if (bus.start) begin
                    level_next = LVL_W'(1);
                    lives_next = LIV_W'(LIVES);
                    state_next = ST_PLAY;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.win          = (state_reg == ST_WIN);
    assign bus.lose         = (state_reg == ST_LOSE);
    assign bus.game_over    = (state_reg == ST_GAMEOVER);
    assign bus.enable_sound = (state_reg == ST_BUZ);
    assign bus.level        = level_reg;
    assign bus.lives        = lives_reg;
    assign bus.sound_freq   = freq_reg;

    // Thermometer: log gi is active once level exceeds gi
    for (genvar gi = 0; gi < NUM_LOGS; gi++) begin : g_log
        assign bus.log_enable[gi] = (int'(level_reg) > gi);
    end

endmodule
